kyber_axil_ctrl_slave: RTL and testbench

//  AXI4-Lite responder (slave) register block that terminates the S00_AXI/S01_AXI

---
 rtl/kyber_axil_ctrl_slave.sv | 218 +++++++++++++++++++++
 tb/tb_kyber_axil_ctrl_slave.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kyber_axil_ctrl_slave.sv
// kyber_axil_ctrl_slave
// AXI4-Lite control/status register block for the Kyber512 CCAKEM masked core.
//   0x0 CTRL   (bit0 is a self-clearing start request)
//   0x4 OP_A
//   0x8 OP_B
//   0xC STATUS {30'b0, busy_i, done_sticky}, bit0 write-one-to-clear
// Build option: define KYBER_AXIL_PROT_CHECK_EN to refuse unprivileged writes
// (AWPROT[0]=0) to CTRL; such writes are dropped and answered with SLVERR.
module kyber_axil_ctrl_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl_o,
  output logic                            start_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   op_a_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   op_b_o,
  input  logic                            busy_i,
  input  logic                            done_i
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;

  logic          ready_en;
  logic          aw_held;
  logic [1:0]    aw_idx;
  logic          w_held;
  logic [DW-1:0] w_data;
  logic [SW-1:0] w_strb;
  logic [DW-1:0] reg_ctrl;
  logic [DW-1:0] reg_op_a;
  logic [DW-1:0] reg_op_b;
  logic          done_sticky;
  logic          start_q;
  logic          bvalid_q;
  logic [1:0]    bresp_q;
  logic          rvalid_q;
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] rd_mux;
  logic          aw_hs;
  logic          w_hs;
  logic          ar_hs;
  logic          do_write;
  logic          wr_blocked;
  logic          wr_en;
  logic          unused_inputs;

  // Byte-lane merge of held write data into an existing register value.
  function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_v,
                                                input logic [DW-1:0] new_v,
                                                input logic [SW-1:0] strb);
    logic [DW-1:0] res;
    res = old_v;
    for (int b = 0; b < SW; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return res;
  endfunction

  // READY is gated by ready_en so every READY output is low throughout reset.
  assign S_AXI_AWREADY = ready_en && !aw_held && !bvalid_q;
  assign S_AXI_WREADY  = ready_en && !w_held && !bvalid_q;
  assign S_AXI_ARREADY = ready_en && !rvalid_q;

  assign aw_hs    = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs     = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs    = S_AXI_ARVALID && S_AXI_ARREADY;
  assign do_write = aw_held && w_held;
  assign wr_en    = do_write && !wr_blocked;

`ifdef KYBER_AXIL_PROT_CHECK_EN
  logic aw_priv;

  // Capture the privilege bit of the accepted write address.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN)  aw_priv <= 1'b0;
    else if (aw_hs)      aw_priv <= S_AXI_AWPROT[0];
  end

  assign wr_blocked    = (aw_idx == 2'd0) && !aw_priv;
  assign unused_inputs = ^{S_AXI_AWPROT[2:1], S_AXI_ARPROT,
                           S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
`else
  assign wr_blocked    = 1'b0;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
`endif

  // Release the READY gate one clock after reset deasserts.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) ready_en <= 1'b0;
    else                ready_en <= 1'b1;
  end

  // AW and W holding registers, filled independently, emptied by the update.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_held <= 1'b0;
      aw_idx  <= 2'd0;
      w_held  <= 1'b0;
      w_data  <= '0;
      w_strb  <= '0;
    end else begin
      if (do_write) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_idx  <= S_AXI_AWADDR[3:2];
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
    end
  end

  // Register file update; CTRL bit0 is never stored, it only fires start_o.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      reg_ctrl <= '0;
      reg_op_a <= '0;
      reg_op_b <= '0;
      start_q  <= 1'b0;
    end else begin
      start_q <= wr_en && (aw_idx == 2'd0) && w_strb[0] && w_data[0];
      if (wr_en) begin
        case (aw_idx)
          2'd0:    reg_ctrl <= merge_bytes(reg_ctrl, w_data, w_strb) & ~DW'(1);
          2'd1:    reg_op_a <= merge_bytes(reg_op_a, w_data, w_strb);
          2'd2:    reg_op_b <= merge_bytes(reg_op_b, w_data, w_strb);
          default: ;
        endcase
      end
    end
  end

  // Sticky done flag; a done_i pulse beats a simultaneous write-one-to-clear.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN)
      done_sticky <= 1'b0;
    else if (done_i)
      done_sticky <= 1'b1;
    else if (wr_en && (aw_idx == 2'd3) && w_strb[0] && w_data[0])
      done_sticky <= 1'b0;
  end

  // Write response, raised together with the register update.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      bvalid_q <= 1'b0;
      bresp_q  <= 2'b00;
    end else if (do_write) begin
      bvalid_q <= 1'b1;
      bresp_q  <= wr_blocked ? 2'b10 : 2'b00;
    end else if (bvalid_q && S_AXI_BREADY) begin
      bvalid_q <= 1'b0;
    end
  end

  // Read mux over the current register values (pre-update on a same-cycle write).
  always_comb begin
    rd_mux = '0;
    case (S_AXI_ARADDR[3:2])
      2'd0:    rd_mux = reg_ctrl;
      2'd1:    rd_mux = reg_op_a;
      2'd2:    rd_mux = reg_op_b;
      default: rd_mux = {{(DW-2){1'b0}}, busy_i, done_sticky};
    endcase
  end

  // Read data/valid, held until the master accepts it.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_mux;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

  assign S_AXI_BVALID = bvalid_q;
  assign S_AXI_BRESP  = bresp_q;
  assign S_AXI_RVALID = rvalid_q;
  assign S_AXI_RDATA  = rdata_q;
  assign S_AXI_RRESP  = 2'b00;
  assign ctrl_o       = reg_ctrl;
  assign op_a_o       = reg_op_a;
  assign op_b_o       = reg_op_b;
  assign start_o      = start_q;

endmodule

// File: tb/tb_kyber_axil_ctrl_slave.sv
// Testbench for kyber_axil_ctrl_slave: directed vector table, hand-built
// corner sequences and a randomized phase against a register-map model.
module tb_kyber_axil_ctrl_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [3:0]  araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] ctrl_o;
  logic        start_o;
  logic [31:0] op_a_o;
  logic [31:0] op_b_o;
  logic        busy_i = 1'b0;
  logic        done_i = 1'b0;

  kyber_axil_ctrl_slave dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .ctrl_o(ctrl_o), .start_o(start_o), .op_a_o(op_a_o), .op_b_o(op_b_o),
    .busy_i(busy_i), .done_i(done_i)
  );

  always #5 clk = ~clk;

`ifdef KYBER_AXIL_PROT_CHECK_EN
  localparam bit PROT_CHECK = 1'b1;
`else
  localparam bit PROT_CHECK = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;

  // Reference model: the register map as plain values.
  logic [31:0] m_reg [0:3];
  bit          m_done = 1'b0;
  bit          m_busy = 1'b0;

  always @(posedge clk) if (rst_n && start_o) start_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit hit, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: no handshake within cycle budget", name);
  endtask

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v, input logic [31:0] new_v,
                                              input logic [3:0] strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

  task automatic model_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic [2:0] prot, output logic [1:0] eresp, output int estart);
    int idx;
    bit blocked;
    idx = int'(addr) / 4;
    blocked = PROT_CHECK && idx == 0 && !prot[0];
    eresp = blocked ? 2'b10 : 2'b00;
    estart = 0;
    if (!blocked) begin
      if (idx == 0) begin
        m_reg[0] = merge_bytes(m_reg[0], data, strb) & 32'hFFFF_FFFE;
        estart = (strb[0] && data[0]) ? 1 : 0;
      end else if (idx == 3) begin
        if (strb[0] && data[0]) m_done = 1'b0;
      end else begin
        m_reg[idx] = merge_bytes(m_reg[idx], data, strb);
      end
    end
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] addr);
    int idx;
    idx = int'(addr) / 4;
    if (idx == 3) return {30'd0, m_busy, m_done};
    return m_reg[idx];
  endfunction

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [2:0] prot, input int aw_dly, input int w_dly, input int br_dly,
                           input bit done_upd, output logic [1:0] resp, output int lat);
    bit aw_done;
    bit w_done;
    int cyc;
    aw_done = 0; w_done = 0; cyc = 0; resp = 2'b11; lat = -1;
    awaddr = addr; awprot = prot; wdata = data; wstrb = strb;
    while (!(aw_done && w_done)) begin
      @(negedge clk);
      if (cyc > 100) begin
        timeout("write_addr_data");
        awvalid = 0; wvalid = 0;
        return;
      end
      if (aw_done) check("awready_low_while_aw_held", {31'd0, awready}, 32'd0);
      if (w_done)  check("wready_low_while_w_held", {31'd0, wready}, 32'd0);
      awvalid = !aw_done && cyc >= aw_dly;
      wvalid  = !w_done && cyc >= w_dly;
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready) w_done = 1;
      cyc++;
    end
    lat = 0;
    while (!bvalid) begin
      @(negedge clk);
      lat++;
      awvalid = 0; wvalid = 0;
      done_i = done_upd && lat == 1;
      if (lat > 50) begin
        done_i = 0;
        timeout("write_bvalid");
        return;
      end
    end
    done_i = 0;
    check("ready_low_with_bvalid", {30'd0, awready, wready}, 32'd0);
    for (int k = 0; k < br_dly; k++) begin
      @(negedge clk);
      check("bvalid_held_until_bready", {31'd0, bvalid}, 32'd1);
      check("ready_low_during_bvalid", {30'd0, awready, wready}, 32'd0);
    end
    bready = 1;
    resp = bresp;
    @(negedge clk);
    bready = 0;
    check("bvalid_drop_after_bready", {31'd0, bvalid}, 32'd0);
  endtask

  task automatic axi_read(input logic [3:0] addr, input int ar_dly, input int r_dly, output logic [31:0] data);
    bit done;
    int cyc;
    done = 0; cyc = 0; data = 32'hDEAD_BEEF;
    araddr = addr;
    while (!done) begin
      @(negedge clk);
      if (cyc > 100) begin
        timeout("read_addr");
        arvalid = 0;
        return;
      end
      arvalid = cyc >= ar_dly;
      if (arvalid && arready) done = 1;
      cyc++;
    end
    @(negedge clk);
    arvalid = 0;
    check("rvalid_one_cycle_after_ar", {31'd0, rvalid}, 32'd1);
    cyc = 0;
    while (!rvalid) begin
      @(negedge clk);
      cyc++;
      if (cyc > 50) begin
        timeout("read_rvalid");
        return;
      end
    end
    for (int k = 0; k < r_dly; k++) begin
      @(negedge clk);
      check("rvalid_held_until_rready", {31'd0, rvalid}, 32'd1);
      check("arready_low_during_rvalid", {31'd0, arready}, 32'd0);
    end
    rready = 1;
    data = rdata;
    @(negedge clk);
    rready = 0;
    check("rvalid_drop_after_rready", {31'd0, rvalid}, 32'd0);
  endtask

  typedef struct {
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
    int          exp_start;
  } vec_t;

  initial begin
    vec_t        tbl [14];
    logic [1:0]  resp;
    logic [1:0]  eresp;
    int          estart;
    int          lat;
    int          s0;
    logic [31:0] rd;
    logic [3:0]  ra;
    logic [31:0] rdat;
    logic [3:0]  rstrb;
    logic [2:0]  rprot;
    int          op;
    bit          dupd;

    tbl[0]  = '{1'b1, 4'h4, 32'h0000_0002, 4'hF, 32'h0, 0};
    tbl[1]  = '{1'b1, 4'h8, 32'h0000_0003, 4'hF, 32'h0, 0};
    tbl[2]  = '{1'b0, 4'h4, 32'h0,         4'h0, 32'h0000_0002, 0};
    tbl[3]  = '{1'b0, 4'h8, 32'h0,         4'h0, 32'h0000_0003, 0};
    tbl[4]  = '{1'b1, 4'h0, 32'h0000_0005, 4'hF, 32'h0, 1};
    tbl[5]  = '{1'b0, 4'h0, 32'h0,         4'h0, 32'h0000_0004, 0};
    tbl[6]  = '{1'b1, 4'h4, 32'h0000_0000, 4'hF, 32'h0, 0};
    tbl[7]  = '{1'b1, 4'h4, 32'hAABB_CCDD, 4'h5, 32'h0, 0};
    tbl[8]  = '{1'b0, 4'h4, 32'h0,         4'h0, 32'h00BB_00DD, 0};
    tbl[9]  = '{1'b0, 4'hC, 32'h0,         4'h0, 32'h0000_0000, 0};
    tbl[10] = '{1'b1, 4'h9, 32'h1234_5678, 4'hF, 32'h0, 0};
    tbl[11] = '{1'b0, 4'hA, 32'h0,         4'h0, 32'h1234_5678, 0};
    tbl[12] = '{1'b1, 4'h3, 32'h0000_0101, 4'h2, 32'h0, 0};
    tbl[13] = '{1'b0, 4'h0, 32'h0,         4'h0, 32'h0000_0104, 0};
    for (int i = 0; i < 4; i++) m_reg[i] = 32'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_ready", {29'd0, awready, wready, arready}, 32'd0);
    check("reset_valid", {30'd0, bvalid, rvalid}, 32'd0);
    check("reset_resp", {28'd0, bresp, rresp}, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    check("reset_start", {31'd0, start_o}, 32'd0);
    check("reset_regs", ctrl_o | op_a_o | op_b_o, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].wr) begin
        s0 = start_cnt;
        model_write(tbl[i].addr, tbl[i].data, tbl[i].strb, 3'b001, eresp, estart);
        axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, 3'b001, 0, 0, 0, 1'b0, resp, lat);
        check($sformatf("tbl%0d_bresp", i), {30'd0, resp}, tbl[i].exp);
        check($sformatf("tbl%0d_start_pulses", i), start_cnt - s0, tbl[i].exp_start);
        check($sformatf("tbl%0d_b_latency", i), lat, 32'd2);
      end else begin
        axi_read(tbl[i].addr, 0, 0, rd);
        check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp);
      end
    end
    check("tbl_ctrl_o", ctrl_o, 32'h0000_0104);
    check("tbl_op_a_o", op_a_o, 32'h00BB_00DD);
    check("tbl_op_b_o", op_b_o, 32'h1234_5678);

    // AW two cycles ahead of W, BREADY held off; then W ahead of AW
    model_write(4'h4, 32'h0000_0011, 4'hF, 3'b001, eresp, estart);
    axi_write(4'h4, 32'h0000_0011, 4'hF, 3'b001, 0, 2, 3, 1'b0, resp, lat);
    check("aw_early_bresp", {30'd0, resp}, 32'd0);
    check("aw_early_latency", lat, 32'd2);
    model_write(4'h8, 32'h0000_0022, 4'hF, 3'b001, eresp, estart);
    axi_write(4'h8, 32'h0000_0022, 4'hF, 3'b001, 3, 0, 1, 1'b0, resp, lat);
    axi_read(4'h8, 0, 2, rd);
    check("w_early_readback", rd, 32'h0000_0022);

    // Sticky done, W1C, and W1C colliding with done_i
    @(negedge clk); done_i = 1;
    @(negedge clk); done_i = 0;
    m_done = 1;
    axi_read(4'hC, 0, 0, rd);
    check("done_sticky_set", rd, 32'h1);
    model_write(4'hC, 32'h1, 4'hF, 3'b001, eresp, estart);
    axi_write(4'hC, 32'h1, 4'hF, 3'b001, 0, 0, 0, 1'b0, resp, lat);
    axi_read(4'hC, 0, 0, rd);
    check("done_w1c_clear", rd, 32'h0);
    model_write(4'hC, 32'h1, 4'hF, 3'b001, eresp, estart);
    m_done = 1;
    axi_write(4'hC, 32'h1, 4'hF, 3'b001, 0, 0, 0, 1'b1, resp, lat);
    axi_read(4'hC, 0, 0, rd);
    check("done_set_beats_w1c", rd, 32'h1);
    busy_i = 1; m_busy = 1;
    axi_read(4'hC, 1, 0, rd);
    check("status_busy", rd, 32'h3);
    busy_i = 0; m_busy = 0;

    // Read and write to the same register in the update cycle: old value returned
    @(negedge clk);
    check("same_cycle_idle_ready", {30'd0, awready, wready}, 32'd3);
    awaddr = 4'h8; awprot = 3'b001; wdata = 32'hCAFE_F00D; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0; araddr = 4'h8; arvalid = 1;
    check("same_cycle_arready", {31'd0, arready}, 32'd1);
    @(negedge clk);
    arvalid = 0;
    check("same_cycle_valids", {30'd0, bvalid, rvalid}, 32'd3);
    check("same_cycle_old_value", rdata, m_reg[2]);
    bready = 1; rready = 1;
    @(negedge clk);
    bready = 0; rready = 0;
    model_write(4'h8, 32'hCAFE_F00D, 4'hF, 3'b001, eresp, estart);
    axi_read(4'h8, 0, 0, rd);
    check("same_cycle_new_value", rd, 32'hCAFE_F00D);

    // Unprivileged write to CTRL
    s0 = start_cnt;
    model_write(4'h0, 32'h1, 4'hF, 3'b000, eresp, estart);
    axi_write(4'h0, 32'h1, 4'hF, 3'b000, 0, 0, 0, 1'b0, resp, lat);
`ifdef KYBER_AXIL_PROT_CHECK_EN
    check("prot_ctrl_slverr", {30'd0, resp}, 32'h2);
    check("prot_ctrl_no_start", start_cnt - s0, 32'd0);
    model_write(4'h4, 32'h77, 4'hF, 3'b000, eresp, estart);
    axi_write(4'h4, 32'h77, 4'hF, 3'b000, 0, 0, 0, 1'b0, resp, lat);
    check("prot_other_okay", {30'd0, resp}, 32'h0);
    check("prot_other_written", op_a_o, 32'h77);
`else
    check("noprot_ctrl_okay", {30'd0, resp}, 32'h0);
    check("noprot_ctrl_start", start_cnt - s0, 32'd1);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 250; i++) begin
      op = int'($urandom_range(0, 9));
      ra = 4'($urandom_range(0, 15));
      if (op < 4) begin
        rdat = $urandom;
        rstrb = 4'($urandom_range(0, 15));
        rprot = 3'($urandom_range(0, 7));
        dupd = ($urandom_range(0, 3) == 0);
        s0 = start_cnt;
        model_write(ra, rdat, rstrb, rprot, eresp, estart);
        if (dupd) m_done = 1;
        axi_write(ra, rdat, rstrb, rprot, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), dupd, resp, lat);
        check("rand_bresp", {30'd0, resp}, {30'd0, eresp});
        check("rand_start_pulses", start_cnt - s0, estart);
        check("rand_b_latency", lat, 32'd2);
      end else if (op < 8) begin
        axi_read(ra, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rd);
        check("rand_rdata", rd, model_read(ra));
      end else if (op == 8) begin
        @(negedge clk); done_i = 1;
        @(negedge clk); done_i = 0;
        m_done = 1;
      end else begin
        @(negedge clk);
        busy_i = $urandom_range(0, 1) == 1;
        m_busy = busy_i;
      end
    end
    check("rand_ctrl_o", ctrl_o, m_reg[0]);
    check("rand_op_a_o", op_a_o, m_reg[1]);
    check("rand_op_b_o", op_b_o, m_reg[2]);

    // Reset with a read response and a write address pending
    @(negedge clk);
    check("prereset_idle", {30'd0, awready, arready}, 32'd3);
    awaddr = 4'h4; awprot = 3'b001; awvalid = 1; araddr = 4'h4; arvalid = 1;
    @(negedge clk);
    awvalid = 0; arvalid = 0;
    check("prereset_rvalid", {31'd0, rvalid}, 32'd1);
    #2 rst_n = 0;
    #1;
    check("reset_drops_rvalid", {31'd0, rvalid}, 32'd0);
    check("reset_clears_op_a", op_a_o, 32'd0);
    @(negedge clk);
    rst_n = 1;
    wdata = 32'h5555_AAAA; wstrb = 4'hF; wvalid = 1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      wvalid = 0;
      check("no_response_after_reset", {30'd0, bvalid, rvalid}, 32'd0);
    end
    check("dropped_aw_no_update", op_a_o, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
